// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer: drives a shared multi-cycle adder through a raw
// pass and an optional correction pass by M, returning a registered result.
module mod_addsub_ctrl #(
  parameter int WIDTH = 1027
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE1, S_WAIT1, S_ISSUE2, S_WAIT2, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, m_r, t_r;
  logic             op_r;
  logic             pass2;
  logic             carry;
  logic [WIDTH-1:0] sum;

  assign carry = add_result[WIDTH];
  assign sum   = add_result[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_ISSUE1;
      S_ISSUE1: state_nxt = S_WAIT1;
      S_WAIT1:  if (add_done) state_nxt = (op_r && !carry) ? S_DONE : S_ISSUE2;
      S_ISSUE2: state_nxt = S_WAIT2;
      S_WAIT2:  if (add_done) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Adder port is a pure mux of latched registers keyed by state: no path from add_result.
  assign pass2        = (state == S_ISSUE2) || (state == S_WAIT2);
  assign add_start    = (state == S_ISSUE1) || (state == S_ISSUE2);
  assign add_a        = pass2 ? t_r : a_r;
  assign add_b        = pass2 ? m_r : b_r;
  assign add_subtract = pass2 ? ~op_r : op_r;
  assign done         = (state == S_DONE);
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_r    <= '0;
      b_r    <= '0;
      m_r    <= '0;
      t_r    <= '0;
      op_r   <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          a_r  <= in_a;
          b_r  <= in_b;
          m_r  <= in_m;
          op_r <= op;
        end
        S_WAIT1: if (add_done) begin
          t_r <= sum;
          if (op_r && !carry) result <= sum;
        end
        // add: sign set means t < M, keep t; sub: t+M wraps back into range
        S_WAIT2: if (add_done) result <= (!op_r && carry) ? t_r : sum;
        default: ;
      endcase
    end
  end

endmodule
